round_controller: RTL and testbench

Game sequencer that owns the round countdown timer: it starts games, issues the `new_round` reload pulse, gates the timer with `game_state`, counts player hits and score, and ends the game on timer expiry or after the final round. It sits between the debounced button/sensor inputs and the countdown timer and seven-segment display path, in the `clk` domain. It uses the same 1 Hz `clk_1` enable pulse as the timer.

---
 rtl/round_controller.sv | 143 ++++++++++++++
 tb/tb_round_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/round_controller.sv
// round_controller: game sequencer that owns the round countdown timer.
// It starts games, issues the new_round timer reload pulse, gates the
// timer with game_state, counts hits and BCD score, and ends the game on
// timer expiry or after the final round. All outputs are registered.
module round_controller #(
  parameter int unsigned READY_SECS     = 3,  // clk_1 pulses spent in READY (1..15)
  parameter int unsigned HITS_PER_ROUND = 5,  // hits that complete a round (1..15)
  parameter int unsigned MAX_ROUNDS     = 9   // round that, once won, means VICTORY (1..15)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1,
  input  logic       start,
  input  logic       hit,
  input  logic       timer_expired,
  output logic       new_round,
  output logic       game_state,
  output logic [2:0] state,
  output logic [3:0] round_num,
  output logic [3:0] hits,
  output logic [3:0] score_s1,
  output logic [3:0] score_s0
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READY     = 3'd1,
    PLAY      = 3'd2,
    ROUND_WIN = 3'd3,
    GAME_OVER = 3'd4,
    VICTORY   = 3'd5
  } state_e;

  localparam logic [3:0] READY_LOAD = 4'(READY_SECS);
  localparam logic [3:0] HITS_LAST  = 4'(HITS_PER_ROUND - 1);
  localparam logic [3:0] ROUND_LAST = 4'(MAX_ROUNDS);
  localparam logic [6:0] SCORE_MAX  = 7'd99;

  state_e     state_q, state_d;
  logic [3:0] ready_cnt_q, ready_cnt_d;
  logic [3:0] round_q, round_d;
  logic [3:0] hits_q, hits_d;
  logic [6:0] score_q, score_d;
  logic [3:0] s1_q, s1_d;
  logic [3:0] s0_q, s0_d;
  logic       new_round_q, new_round_d;
  logic       game_state_q, game_state_d;

  // Next-state and next-output logic for the game sequence.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    ready_cnt_d = ready_cnt_q;
    round_d     = round_q;
    hits_d      = hits_q;
    score_d     = score_q;
    new_round_d = 1'b0;

    case (state_q)
      IDLE, GAME_OVER, VICTORY: begin
        // End states hold counters for display until a new game starts.
        if (start) begin
          state_d     = READY;
          round_d     = 4'd1;
          hits_d      = 4'd0;
          score_d     = 7'd0;
          ready_cnt_d = READY_LOAD;
          new_round_d = 1'b1;
        end
      end
      READY: begin
        if (clk_1) begin
          if (ready_cnt_q == 4'd1) state_d = PLAY;
          else                     ready_cnt_d = ready_cnt_q - 4'd1;
        end
      end
      PLAY: begin
        // A hit is always counted, even when the timer expires in the same cycle.
        if (hit) begin
          hits_d = hits_q + 4'd1;
          if (score_q != SCORE_MAX) score_d = score_q + 7'd1;
        end
        if (hit && hits_q == HITS_LAST) state_d = ROUND_WIN;
        else if (timer_expired)         state_d = GAME_OVER;
      end
      ROUND_WIN: begin
        if (round_q == ROUND_LAST) begin
          state_d = VICTORY;
        end else begin
          state_d     = READY;
          round_d     = round_q + 4'd1;
          hits_d      = 4'd0;
          ready_cnt_d = READY_LOAD;
          new_round_d = 1'b1;
        end
      end
      default: state_d = IDLE;  // unused codes 6 and 7 recover to IDLE
    endcase

    game_state_d = (state_d == PLAY);
    s1_d         = 4'(score_d / 7'd10);
    s0_d         = 4'(score_d % 7'd10);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge (synchronous), so it is tested
    // inside the clocked block rather than in the sensitivity list.
    if (rst) begin
      state_q      <= IDLE;
      ready_cnt_q  <= 4'd0;
      round_q      <= 4'd0;
      hits_q       <= 4'd0;
      score_q      <= 7'd0;
      s1_q         <= 4'd0;
      s0_q         <= 4'd0;
      new_round_q  <= 1'b0;
      game_state_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      state_q      <= state_d;
      ready_cnt_q  <= ready_cnt_d;
      round_q      <= round_d;
      hits_q       <= hits_d;
      score_q      <= score_d;
      s1_q         <= s1_d;
      s0_q         <= s0_d;
      new_round_q  <= new_round_d;
      game_state_q <= game_state_d;
    end
  end

  assign state      = state_q;
  assign new_round  = new_round_q;
  assign game_state = game_state_q;
  assign round_num  = round_q;
  assign hits       = hits_q;
  assign score_s1   = s1_q;
  assign score_s0   = s0_q;

endmodule

// File: tb/tb_round_controller.sv
// Testbench for round_controller: two instances (default parameters and a
// 15-round / 15-hit build for score saturation) share one directed stimulus.
// A behavioural game model predicts every output each cycle; literal
// expectations at key points pin the model.
module tb_round_controller;

  logic clk           = 1'b0;
  logic rst           = 1'b1;
  logic clk_1         = 1'b0;
  logic start         = 1'b0;
  logic hit           = 1'b0;
  logic timer_expired = 1'b0;

  logic       a_new_round, a_game_state, b_new_round, b_game_state;
  logic [2:0] a_state, b_state;
  logic [3:0] a_round, a_hits, a_s1, a_s0;
  logic [3:0] b_round, b_hits, b_s1, b_s0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_q    = 0;

  round_controller #(.READY_SECS(3), .HITS_PER_ROUND(5), .MAX_ROUNDS(9)) dut_a (
    .clk(clk), .rst(rst), .clk_1(clk_1), .start(start), .hit(hit),
    .timer_expired(timer_expired), .new_round(a_new_round), .game_state(a_game_state),
    .state(a_state), .round_num(a_round), .hits(a_hits),
    .score_s1(a_s1), .score_s0(a_s0)
  );

  round_controller #(.READY_SECS(3), .HITS_PER_ROUND(15), .MAX_ROUNDS(15)) dut_b (
    .clk(clk), .rst(rst), .clk_1(clk_1), .start(start), .hit(hit),
    .timer_expired(timer_expired), .new_round(b_new_round), .game_state(b_game_state),
    .state(b_state), .round_num(b_round), .hits(b_hits),
    .score_s1(b_s1), .score_s0(b_s0)
  );

  always #5 clk = ~clk;

  // Game model: phase numbers are the display codes the outputs must show.
  typedef struct {
    int st;
    int round;
    int hits;
    int score;
    int ready_left;
    int new_round;
    int game_state;
  } model_t;

  model_t ma = '{default: 0};
  model_t mb = '{default: 0};

  function automatic model_t m_next(input model_t m, input int secs, input int hpr,
                                    input int maxr, input logic r, input logic c1,
                                    input logic s, input logic h, input logic te);
    model_t n = m;
    n.new_round = 0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (m.st == 0 || m.st == 4 || m.st == 5) begin
      if (s) begin
        n.st = 1; n.round = 1; n.hits = 0; n.score = 0;
        n.ready_left = secs; n.new_round = 1;
      end
    end else if (m.st == 1) begin
      if (c1) begin
        n.ready_left = m.ready_left - 1;
        if (n.ready_left == 0) n.st = 2;
      end
    end else if (m.st == 2) begin
      if (h) begin
        n.hits  = m.hits + 1;
        n.score = (m.score + 1 > 99) ? 99 : m.score + 1;
      end
      if (h && n.hits == hpr) n.st = 3;
      else if (te)            n.st = 4;
    end else if (m.st == 3) begin
      if (m.round == maxr) n.st = 5;
      else begin
        n.st = 1; n.round = m.round + 1; n.hits = 0;
        n.ready_left = secs; n.new_round = 1;
      end
    end
    n.game_state = (n.st == 2) ? 1 : 0;
    return n;
  endfunction

  // Advance the models on the same edge the DUTs sample their inputs.
  always @(posedge clk) begin
    ma    <= m_next(ma, 3, 5, 9, rst, clk_1, start, hit, timer_expired);
    mb    <= m_next(mb, 3, 15, 15, rst, clk_1, start, hit, timer_expired);
    cyc_q <= cyc_q + 1;
  end

  task automatic check(input string name, input logic [7:0] act, input int exp);
    n_checks++;
    if (act === 8'(exp)) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cmp_dut(input string tag, input model_t m, input logic [2:0] st,
                         input logic gs, input logic nr, input logic [3:0] rn,
                         input logic [3:0] hc, input logic [3:0] s1, input logic [3:0] s0);
    check({tag, ".state"},      8'(st), m.st);
    check({tag, ".game_state"}, 8'(gs), m.game_state);
    check({tag, ".new_round"},  8'(nr), m.new_round);
    check({tag, ".round_num"},  8'(rn), m.round);
    check({tag, ".hits"},       8'(hc), m.hits);
    check({tag, ".score_s1"},   8'(s1), m.score / 10);
    check({tag, ".score_s0"},   8'(s0), m.score % 10);
  endtask

  // Compare both DUTs against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cyc_q > 0) begin
      cmp_dut("A", ma, a_state, a_game_state, a_new_round, a_round, a_hits, a_s1, a_s0);
      cmp_dut("B", mb, b_state, b_game_state, b_new_round, b_round, b_hits, b_s1, b_s0);
    end
  end

  // Apply one cycle of inputs and return at the next falling edge.
  task automatic step(input logic r, input logic c1, input logic s,
                      input logic h, input logic te);
    rst = r; clk_1 = c1; start = s; hit = h; timer_expired = te;
    @(negedge clk);
  endtask

  task automatic idle();  step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic tick();  step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic hit_p(); step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic go();    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); endtask

  task automatic all_zero(input string tag);
    check({tag, ".state"},      8'(a_state), 0);
    check({tag, ".game_state"}, 8'(a_game_state), 0);
    check({tag, ".new_round"},  8'(a_new_round), 0);
    check({tag, ".round_num"},  8'(a_round), 0);
    check({tag, ".hits"},       8'(a_hits), 0);
    check({tag, ".score_s1"},   8'(a_s1), 0);
    check({tag, ".score_s0"},   8'(a_s0), 0);
  endtask

  initial begin
    @(negedge clk);
    all_zero("reset");

    // Start a game: one new_round pulse on READY entry.
    go();
    check("start.new_round", 8'(a_new_round), 1);
    check("start.state", 8'(a_state), 1);
    check("start.round_num", 8'(a_round), 1);
    go();  // start ignored in READY
    check("ready_start.new_round", 8'(a_new_round), 0);
    check("ready_start.state", 8'(a_state), 1);
    tick(); tick();
    check("ready2.state", 8'(a_state), 1);
    tick();
    check("play.state", 8'(a_state), 2);
    check("play.game_state", 8'(a_game_state), 1);

    // Five hits win round 1.
    for (int i = 1; i <= 4; i++) begin
      hit_p();
      check("round1.hits", 8'(a_hits), i);
    end
    hit_p();
    check("round_win.state", 8'(a_state), 3);
    idle();
    check("round2.state", 8'(a_state), 1);
    check("round2.round_num", 8'(a_round), 2);
    check("round2.hits", 8'(a_hits), 0);
    check("round2.new_round", 8'(a_new_round), 1);
    check("round2.score_s1", 8'(a_s1), 0);
    check("round2.score_s0", 8'(a_s0), 5);
    idle();
    check("round2.new_round_low", 8'(a_new_round), 0);

    // Expiry with hits=2 ends the game; counters held, hits ignored.
    tick(); tick(); tick();
    go();  // start ignored in PLAY
    check("play_start.state", 8'(a_state), 2);
    check("play_start.new_round", 8'(a_new_round), 0);
    hit_p(); hit_p();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("expire.state", 8'(a_state), 4);
    check("expire.game_state", 8'(a_game_state), 0);
    check("expire.hits", 8'(a_hits), 2);
    check("expire.round_num", 8'(a_round), 2);
    hit_p();
    check("over_hit.hits", 8'(a_hits), 2);
    check("over_hit.score_s0", 8'(a_s0), 7);
    go();
    check("restart.state", 8'(a_state), 1);
    check("restart.round_num", 8'(a_round), 1);
    check("restart.score_s0", 8'(a_s0), 0);

    // Simultaneous hit and expiry: completing hit wins the round.
    tick(); tick(); tick();
    repeat (4) hit_p();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("simul_win.state", 8'(a_state), 3);
    idle();
    check("simul_win.round_num", 8'(a_round), 2);
    tick(); tick(); tick();
    repeat (3) hit_p();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("simul_lose.hits", 8'(a_hits), 4);
    check("simul_lose.state", 8'(a_state), 4);

    // Win all nine rounds.
    go();
    for (int r = 1; r <= 9; r++) begin
      tick(); tick(); tick();
      repeat (5) hit_p();
      idle();
    end
    check("victory.state", 8'(a_state), 5);
    check("victory.score_s1", 8'(a_s1), 4);
    check("victory.score_s0", 8'(a_s0), 5);
    check("victory.round_num", 8'(a_round), 9);

    // Reset mid-READY.
    go();
    tick();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    all_zero("rst_ready");
    idle();

    // Reset mid-PLAY, asserted together with start and hit.
    go();
    tick(); tick(); tick();
    hit_p();
    check("pre_rst.hits", 8'(a_hits), 1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    all_zero("rst_play");

    // Saturation: 15x15 build scores 225 hits but displays 99.
    go();
    repeat (400) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("sat.state", 8'(b_state), 5);
    check("sat.round_num", 8'(b_round), 15);
    check("sat.score_s1", 8'(b_s1), 9);
    check("sat.score_s0", 8'(b_s0), 9);
    check("sat_a.state", 8'(a_state), 5);
    check("sat_a.score_s0", 8'(a_s0), 5);

    idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
